// File: rtl/invert_pkg.sv
// invert_pkg: shared constants for the bit-serial two's-complement negator
package invert_pkg;
  localparam int WORD_LEN_DEF = 0;
  function automatic int cnt_w(input int len);
    return len > 1 ? $clog2(len) : 1;
  endfunction
endpackage

// File: rtl/invert_ctrl.sv
// invert_ctrl: tracks whether a 1 has been accepted in the current serial word
module invert_ctrl import invert_pkg::*; #(
  parameter int WORD_LEN = WORD_LEN_DEF
) (
  input  logic t_clk,
  input  logic r,
  input  logic i,
  output logic seen_one
);
  if (WORD_LEN == 0) begin : g_free
    always_ff @(posedge t_clk)
      seen_one <= r ? (seen_one | i) : 1'b0;
  end else begin : g_word
    localparam int CW = cnt_w(WORD_LEN);
    logic [CW-1:0] bit_cnt;
    logic last;
    assign last = bit_cnt == CW'(WORD_LEN - 1);
    // reset takes priority over the word wrap; both clear the same state
    always_ff @(posedge t_clk) begin
      seen_one <= (r && !last) ? (seen_one | i) : 1'b0;
      bit_cnt  <= (r && !last) ? bit_cnt + CW'(1) : '0;
    end
  end
endmodule

// File: rtl/invert.sv
// invert: zero-latency bit-serial two's-complement negator, LSB first
module invert import invert_pkg::*; #(
  parameter int WORD_LEN = WORD_LEN_DEF
) (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);
  logic seen_one;
  invert_ctrl #(.WORD_LEN(WORD_LEN)) u_ctrl (
    .t_clk    (t_clk),
    .r        (r),
    .i        (i),
    .seen_one (seen_one)
  );
  // gating with r keeps y a clean pass-through during reset, even before the first edge
  assign y = i ^ (seen_one & r);
endmodule

// File: tb/tb_invert.sv
// tb_invert: directed checks of invert with WORD_LEN=0 and WORD_LEN=4
module tb_invert;
  logic t_clk = 1'b0;
  logic i = 1'b0;
  logic r = 1'b0;
  logic y0, y4;
  int checks = 0;
  int errors = 0;

  invert #(.WORD_LEN(0)) u_free (.i(i), .r(r), .t_clk(t_clk), .y(y0));
  invert #(.WORD_LEN(4)) u_word (.i(i), .r(r), .t_clk(t_clk), .y(y4));

  always #100 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic rv);
    @(negedge t_clk);
    i = b;
    r = rv;
    #10;
  endtask

  task automatic run0(input string tag, input logic [7:0] bits, input logic [7:0] exp, input int n);
    for (int k = 0; k < n; k++) begin
      drive(bits[k], 1'b1);
      chk($sformatf("%s[%0d]", tag, k), y0, exp[k]);
    end
  endtask

  task automatic run4(input string tag, input logic [3:0] bits, input logic [3:0] exp);
    for (int k = 0; k < 4; k++) begin
      drive(bits[k], 1'b1);
      chk($sformatf("%s[%0d]", tag, k), y4, exp[k]);
    end
  endtask

  initial begin
    #10;
    chk("pre_edge_y0", y0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(k[0], 1'b0);
      chk($sformatf("rst_pass0[%0d]", k), y0, k[0]);
      chk($sformatf("rst_pass4[%0d]", k), y4, k[0]);
    end
    drive(1'b0, 1'b1);
    chk("rst_seen_clear", y0, 1'b0);
    drive(1'b0, 1'b0);
    run0("neg52", 8'b0000_0000 | 8'b0011_0100, 8'b1100_1100, 8);
    drive(1'b0, 1'b0);
    run0("zeros", 8'h00, 8'h00, 8);
    drive(1'b0, 1'b0);
    run0("mid_a", 8'b0000_0001, 8'b0000_0011, 2);
    drive(1'b1, 1'b0);
    chk("mid_rst_pass", y0, 1'b1);
    run0("mid_b", 8'b0000_0110, 8'b0000_0010, 3);
    drive(1'b0, 1'b0);
    run4("w0110", 4'b0110, 4'b1010);
    run4("w0001", 4'b0001, 4'b1111);
    run4("w1000", 4'b1000, 4'b1000);
    drive(1'b1, 1'b1);
    chk("wrap_b0", y4, 1'b1);
    drive(1'b0, 1'b1);
    chk("wrap_b1", y4, 1'b1);
    drive(1'b0, 1'b1);
    chk("wrap_b2", y4, 1'b1);
    drive(1'b1, 1'b0);
    chk("wrap_rst_pass", y4, 1'b1);
    run4("after_wrap", 4'b0110, 4'b1010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
